// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// It holds the funct3 operation encodings and the FSM state encoding.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Bit-serial RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes.
// A single sign-fixup cycle follows, and divide-by-zero and signed overflow bypass the iteration.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output muldiv_state_t   dbg_state
);

  localparam int CW = ($clog2(XLEN) + 1 > 6) ? $clog2(XLEN) + 1 : 6;
  localparam int PW = XLEN + XLEN;
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state;
  muldiv_op_t      op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, md, res_q;
  logic            neg_q, neg_r, rsp_valid_q, busy_q;

  muldiv_op_t      op_in;
  logic            a_neg, b_neg, div_zero, div_ovf, is_div;
  logic [XLEN-1:0] a_mag, b_mag, fix_val;
  logic [XLEN:0]   add_a, add_b, add_y;
  logic            add_sub;
  logic [PW-1:0]   prod, prod_fix;

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
  // a response transfers on a rising edge with rsp_valid & rsp_ready, and
  // result/rsp_valid hold stable until that edge.
  assign req_ready = (state == S_IDLE) & ~flush;
  assign rsp_valid = rsp_valid_q;
  assign result    = res_q;
  assign busy      = busy_q;
  assign dbg_state = state;

  always_comb begin
    op_in    = muldiv_op_t'(op);
    a_neg    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & a[XLEN-1];
    b_neg    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] & (b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (a == MIN_NEG) & (b == '1);
  end

  // One XLEN+1-bit adder: accumulate for multiply, trial subtract for divide.
  always_comb begin
    is_div  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    add_a   = {1'b0, hi};
    add_b   = lo[0] ? {1'b0, md} : '0;
    add_sub = 1'b0;
    if (is_div) begin
      add_a   = {hi, lo[XLEN-1]};
      add_b   = {1'b0, md};
      add_sub = 1'b1;
    end
    add_y = add_a + (add_sub ? ~add_b : add_b) + (XLEN+1)'(add_sub);
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    case (op_q)
      OP_MUL:                      fix_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:             fix_val = neg_q ? -lo : lo;
      default:                     fix_val = neg_r ? -hi : hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= OP_MUL;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      md          <= '0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      cnt         <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= op_in;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            hi     <= '0;
            lo     <= a_mag;
            md     <= b_mag;
            busy_q <= 1'b1;
            if (div_zero) begin
              state       <= S_DONE;
              res_q       <= op[1] ? a : '1;
              rsp_valid_q <= 1'b1;
            end else if (div_ovf) begin
              state       <= S_DONE;
              res_q       <= (op_in == OP_DIV) ? a : '0;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= S_CALC;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            // A negative trial difference means the divisor did not fit: restore.
            hi <= add_y[XLEN] ? add_a[XLEN-1:0] : add_y[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ~add_y[XLEN]};
          end else begin
            hi <= add_y[XLEN:1];
            lo <= {add_y[0], lo[XLEN-1:1]};
          end
          if (cnt == CW'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          res_q       <= fix_val;
          rsp_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (rsp_ready) begin
            state       <= S_IDLE;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a driver pushes expected result and latency,
// and a negedge monitor pops and compares each response.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          reset, flush, req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [2:0]    op;
  logic [31:0]   a, b, result;
  muldiv_state_t dbg_state;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          last_take = -100;
  bit          mon_en = 1'b0;
  bit          seen = 1'b0;
  logic [31:0] hold_val;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .op(op), .a(a), .b(b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // driver: holds req_valid until accepted; exp_rsp=0 issues an op that will be discarded
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat, input bit exp_rsp, input bit chk_take);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; op = o; a = x; b = y;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: req_ready never high for op %0d", o);
    end else begin
      if (chk_take) chk("accept_after_take", 32'(cyc + 1), 32'(last_take + 1));
      if (exp_rsp) begin
        exp_q.push_back(e);
        lat_q.push_back(lat);
        acc_q.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp: result 0x%08h with nothing outstanding", result);
          end else begin
            chk("result", result, exp_q.pop_front());
            chk("latency", 32'(cyc - acc_q.pop_front() + 1), 32'(lat_q.pop_front()));
          end
          seen = 1'b1;
          hold_val = result;
        end else begin
          chk("held_result", result, hold_val);
        end
        if (stall_cnt > 0) begin
          rsp_ready = 1'b0;
          stall_cnt--;
        end else begin
          rsp_ready = 1'b1;
          seen = 1'b0;
          last_take = cyc + 1;
        end
      end else begin
        if (seen) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_dropped: rsp_valid fell before being taken");
          seen = 1'b0;
        end
        chk("idle_result_zero", result, 32'h0);
        rsp_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    mon_en = 1'b1;

    // multiply family
    issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1, 0);
    issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1, 0);
    issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 1, 0);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1, 0);
    issue(OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 34, 1, 0);
    issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1, 0);
    issue(OP_MULHU,  32'h80000000, 32'd2,        32'h00000001, 34, 1, 0);

    // divide family
    issue(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1, 0);
    issue(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1, 0);
    issue(OP_DIVU, 32'd100,      32'd7,        32'd14,       34, 1, 0);
    issue(OP_REMU, 32'd100,      32'd7,        32'd2,        34, 1, 0);
    issue(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1, 0);
    issue(OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        34, 1, 0);
    issue(OP_DIVU, 32'd5,        32'd9,        32'd0,        34, 1, 0);

    // bypass cases: divide by zero and signed overflow
    issue(OP_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, 1, 1, 0);
    issue(OP_REM,  32'h55,       32'd0,        32'h55,       1, 1, 0);
    issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0);
    issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 1, 0);

    // consumer stalls 5 cycles; next request held valid must wait for the take
    stall_cnt = 5;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1, 0);
    issue(OP_MUL,  32'd6,   32'd9, 32'd54, 34, 1, 1);

    // flush in the middle of CALC
    issue(OP_MUL, 32'h1234, 32'h5678, 32'h0, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("pre_flush_state", 32'(dbg_state), 32'(S_CALC));
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_state", 32'(dbg_state), 32'(S_IDLE));
    chk("flush_busy", 32'(busy), 32'd0);
    issue(OP_MUL, 32'd3, 32'd5, 32'd15, 34, 1, 0);

    // reset in the middle of CALC
    issue(OP_DIVU, 32'hFFFF, 32'd3, 32'h0, 0, 0, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_state", 32'(dbg_state), 32'(S_IDLE));
    chk("midreset_busy", 32'(busy), 32'd0);
    issue(OP_MUL, 32'd3, 32'd5, 32'd15, 34, 1, 0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d responses never arrived", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two >= 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  abandons any accepted, unreturned operation.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a, b  input  XLEN  rs1, rs2 operands; sampled only on accept.
REQ-009 rsp_valid  output  1  result present.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 result  output  XLEN  operation result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Accept SHALL occur on a rising edge with req_valid & req_ready; req_ready SHALL equal (state==IDLE) & ~flush.
REQ-014 FSM SHALL have states IDLE, CALC, FIXUP, DONE.
REQ-015 IDLE->CALC on accept, loading a 6-bit-or-wider iteration counter with XLEN, capturing op and the operand magnitudes (abs value for signed operands per op).
REQ-016 CALC SHALL retire exactly one bit per cycle: shift-add for multiply (2*XLEN-bit product), restoring shift-subtract for divide; counter decrements; CALC->FIXUP when counter reaches 1.
REQ-017 FIXUP SHALL apply sign correction: product negated if operand signs differ (MULH: both signed; MULHSU: a signed only); quotient negated if signs differ; remainder takes the sign of a.
REQ-018 FIXUP->DONE unconditionally; rsp_valid SHALL be high exactly in DONE.
REQ-019 Normal latency: rsp_valid SHALL first assert XLEN+2 rising edges after the accept edge.
REQ-020 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-021 Divide by zero (b==0, ops 100-111) SHALL bypass CALC: IDLE->DONE; DIV/DIVU return all-ones, REM/REMU return a; rsp_valid one edge after accept.
REQ-022 Signed overflow (DIV/REM, a==100..0, b==all-ones) SHALL bypass CALC: DIV returns a, REM returns 0; rsp_valid one edge after accept.
REQ-023 In DONE, result and rsp_valid SHALL hold stable while rsp_ready is low; DONE->IDLE on rsp_valid & rsp_ready.
REQ-024 No new request SHALL be accepted in the same cycle the response is taken (req_ready rises the edge after).
REQ-025 flush high on a rising edge SHALL force IDLE from any state, discard the operation, and produce no rsp_valid; flush outranks accept and response.
REQ-026 result SHALL be 0 whenever rsp_valid is low.

Reset
REQ-027 reset SHALL force state IDLE, counter 0, all datapath registers 0; rsp_valid=0, busy=0, result=0; req_ready=1 on the first edge after reset deasserts.
REQ-028 reset asserted mid-operation SHALL abort it with no response; reset outranks flush and all handshakes.

Structure
REQ-029 Package muldiv_pkg SHALL hold the funct3 op encodings (enum muldiv_op_t) and the FSM state enum (muldiv_state_t).
REQ-030 muldiv_unit SHALL be a single module with no sub-module; the shift-add/shift-subtract datapath shares one XLEN+1-bit adder/subtractor.
REQ-031 No multiply or divide operator SHALL be used in RTL.

Verification (XLEN=32)
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, rsp_valid 34 edges after accept; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 DIVU a=0x1234, b=0 -> 0xFFFFFFFF after 1 edge; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after 1 edge, REM -> 0.
REQ-036 rsp_ready held low 5 cycles in DONE -> result and rsp_valid unchanged; req_valid high throughout -> not accepted until the edge after response taken.
REQ-037 flush (or reset) at CALC cycle 10 -> IDLE next edge, no rsp_valid; following MUL 3*5 -> 15 at normal latency.
